// File: rtl/count_mon_pkg.sv
// Shared types and helpers for the counter stream monitor: FSM states,
// delta classes, default widths and the delta classifier.
package count_mon_pkg;

  localparam int CNT_W_DEFAULT  = 4;
  localparam int STAT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACQ   = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } mon_state_e;

  typedef enum logic [1:0] {
    UP_STEP   = 2'd0,
    DOWN_STEP = 2'd1,
    HOLD      = 2'd2,
    JUMP      = 2'd3
  } delta_class_e;

  // Delta arrives zero-extended to 32 bits; width says how many bits are real.
  // +1 is tested before all-ones so a 1-bit counter still reads as stepping up.
  function automatic delta_class_e classify(input logic [31:0] delta, input int unsigned width);
    logic [31:0] mask;
    logic [31:0] d;
    delta_class_e cls;
    mask = (width >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    d = delta & mask;
    if (d == 32'd0) begin
      cls = HOLD;
    end else if (d == 32'd1) begin
      cls = UP_STEP;
    end else if (d == mask) begin
      cls = DOWN_STEP;
    end else begin
      cls = JUMP;
    end
    return cls;
  endfunction

endpackage

// File: rtl/count_stream_monitor_sat_counter.sv
// Saturating event counter: sticks at all-ones, clear wins over increment.
module sat_counter
  import count_mon_pkg::*;
#(
  parameter int W = STAT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = {W{1'b0}};
    end else if (inc && (value_q != {W{1'b1}})) begin
      value_d = value_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      value_d = value_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      value_q <= {W{1'b0}};
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/count_stream_monitor.sv
// Observer for the up/down counter output: decodes step, wrap, direction
// change, load and illegal hold per valid sample, with saturating statistics.
module count_stream_monitor
  import count_mon_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEFAULT,
  parameter int STAT_W = STAT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic              clr_stats_i,
  output logic              locked_o,
  output logic              dir_o,
  output logic              step_o,
  output logic              wrap_o,
  output logic              dir_chg_o,
  output logic              load_o,
  output logic              err_o,
  output logic [STAT_W-1:0] wrap_cnt_o,
  output logic [STAT_W-1:0] load_cnt_o,
  output logic [STAT_W-1:0] err_cnt_o
);

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic             locked_q, locked_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             dir_chg_q, dir_chg_d;
  logic             load_q, load_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] delta_s;
  delta_class_e     cls_s;
  logic             prev_max_s;
  logic             prev_zero_s;

  assign delta_s     = count_i - prev_q;
  assign cls_s       = classify(32'(delta_s), CNT_W);
  assign prev_max_s  = (prev_q == {CNT_W{1'b1}});
  assign prev_zero_s = (prev_q == {CNT_W{1'b0}});

  // Next-state and event decode; a wrap is judged on the value being left.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    step_d    = 1'b0;
    wrap_d    = 1'b0;
    dir_chg_d = 1'b0;
    load_d    = 1'b0;
    err_d     = 1'b0;
    if (valid_i) begin
      prev_d = count_i;
      case (state_q)
        EMPTY: state_d = ACQ;
        ACQ: begin
          case (cls_s)
            UP_STEP:   begin state_d = UP;   step_d = 1'b1; end
            DOWN_STEP: begin state_d = DOWN; step_d = 1'b1; end
            HOLD:      state_d = ACQ;
            JUMP:      begin state_d = ACQ;  load_d = 1'b1; end
            default:   state_d = ACQ;
          endcase
        end
        UP: begin
          case (cls_s)
            UP_STEP:   begin step_d = 1'b1; wrap_d = prev_max_s; end
            DOWN_STEP: begin
              state_d = DOWN; dir_chg_d = 1'b1; step_d = 1'b1; wrap_d = prev_zero_s;
            end
            HOLD:      err_d = 1'b1;
            JUMP:      begin state_d = ACQ; load_d = 1'b1; end
            default:   state_d = ACQ;
          endcase
        end
        DOWN: begin
          case (cls_s)
            DOWN_STEP: begin step_d = 1'b1; wrap_d = prev_zero_s; end
            UP_STEP:   begin
              state_d = UP; dir_chg_d = 1'b1; step_d = 1'b1; wrap_d = prev_max_s;
            end
            HOLD:      err_d = 1'b1;
            JUMP:      begin state_d = ACQ; load_d = 1'b1; end
            default:   state_d = ACQ;
          endcase
        end
        default: state_d = EMPTY;
      endcase
    end else begin
      state_d = state_q;
      prev_d  = prev_q;
    end
    locked_d = (state_d == UP) || (state_d == DOWN);
    dir_d    = (state_d == UP);
  end

  // State, previous sample and registered event outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= EMPTY;
      prev_q    <= {CNT_W{1'b0}};
      locked_q  <= 1'b0;
      dir_q     <= 1'b0;
      step_q    <= 1'b0;
      wrap_q    <= 1'b0;
      dir_chg_q <= 1'b0;
      load_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      locked_q  <= locked_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      wrap_q    <= wrap_d;
      dir_chg_q <= dir_chg_d;
      load_q    <= load_d;
      err_q     <= err_d;
    end
  end

  assign locked_o  = locked_q;
  assign dir_o     = dir_q;
  assign step_o    = step_q;
  assign wrap_o    = wrap_q;
  assign dir_chg_o = dir_chg_q;
  assign load_o    = load_q;
  assign err_o     = err_q;

  sat_counter #(.W(STAT_W)) u_wrap_cnt (
    .clk(clk), .reset(reset), .inc(wrap_d), .clr(clr_stats_i), .value(wrap_cnt_o)
  );

  sat_counter #(.W(STAT_W)) u_load_cnt (
    .clk(clk), .reset(reset), .inc(load_d), .clr(clr_stats_i), .value(load_cnt_o)
  );

  sat_counter #(.W(STAT_W)) u_err_cnt (
    .clk(clk), .reset(reset), .inc(err_d), .clr(clr_stats_i), .value(err_cnt_o)
  );

endmodule
